// File: rtl/iir_pkg.sv
// Shared constants and state encoding for the filter output checker.
// Defaults match the my_iir reference run.
package iir_pkg;

  localparam int NB         = 12;
  localparam int AW         = 9;
  localparam int NSAMP_DEF  = 501;
  localparam int TOL_DEF    = 1;
  localparam int TO_CYC_DEF = 1024;
  localparam int CW_DEF     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exp_ram.sv
// Expected-sample table: registers, synchronous write, asynchronous read.
// Contents survive reset.
module exp_ram #(
  parameter int NB = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NB-1:0] rdata
);

  logic [NB-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_checker.sv
// Receive-side checker for the filter output stream: compares each
// valid sample against a preloaded table within a tolerance.
module iir_out_checker #(
  parameter int NB     = iir_pkg::NB,
  parameter int AW     = iir_pkg::AW,
  parameter int NSAMP  = iir_pkg::NSAMP_DEF,
  parameter int TOL    = iir_pkg::TOL_DEF,
  parameter int TO_CYC = iir_pkg::TO_CYC_DEF,
  parameter int CW     = iir_pkg::CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          START,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [NB-1:0] LD_DATA,
  input  logic          VIN,
  input  logic [NB-1:0] DIN,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic          TIMEOUT,
  output logic [CW-1:0] ERR_CNT,
  output logic [AW:0]   SMP_CNT,
  output logic [AW-1:0] FIRST_ERR_IDX
);

  import iir_pkg::*;

  localparam int WW = $clog2(TO_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TO_CYC - 1);
  localparam logic [WW-1:0] WD_ONE = WW'(1);
  localparam logic [AW:0] S_LAST = (AW+1)'(NSAMP - 1);
  localparam logic [AW:0] S_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] E_ONE = CW'(1);
  localparam logic [NB:0] D_ONE = (NB+1)'(1);
  localparam logic [NB:0] D_TOL = (NB+1)'(TOL);

  state_t state, state_nxt;

  logic [AW:0]   smp_cnt;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] first_idx;
  logic          tmo_q;
  logic          pass_q;
  logic [WW-1:0] wdog;

  logic [NB-1:0] exp_smp;
  logic [NB:0]   diff;
  logic [NB:0]   mag;
  logic          mism;
  logic          in_run;
  logic          acc;
  logic          last;
  logic          wd_exp;

  exp_ram #(
    .NB(NB),
    .AW(AW)
  ) u_ram (
    .clk  (CLK),
    .we   (LD_EN && state != S_RUN),
    .waddr(LD_ADDR),
    .wdata(LD_DATA),
    .raddr(smp_cnt[AW-1:0]),
    .rdata(exp_smp)
  );

  // Sign-extend both sides so full-scale differences cannot wrap.
  assign diff = {DIN[NB-1], DIN} - {exp_smp[NB-1], exp_smp};
  assign mag  = diff[NB] ? (~diff + D_ONE) : diff;
  assign mism = mag > D_TOL;

  assign in_run = (state == S_RUN) && !START;
  assign acc    = in_run && VIN;
  assign last   = smp_cnt == S_LAST;
  assign wd_exp = in_run && !VIN && (wdog == WD_LAST);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (START) state_nxt = S_RUN;
      S_RUN: begin
        if (START)                    state_nxt = S_RUN;
        else if ((acc && last) || wd_exp) state_nxt = S_DONE;
      end
      S_DONE: if (START) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY          = state == S_RUN;
    DONE          = state == S_DONE;
    PASS          = pass_q;
    TIMEOUT       = tmo_q;
    ERR_CNT       = err_cnt;
    SMP_CNT       = smp_cnt;
    FIRST_ERR_IDX = first_idx;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      smp_cnt   <= '0;
      err_cnt   <= '0;
      first_idx <= '0;
      tmo_q     <= 1'b0;
      pass_q    <= 1'b0;
      wdog      <= '0;
    end else if (START) begin
      smp_cnt   <= '0;
      err_cnt   <= '0;
      first_idx <= '0;
      tmo_q     <= 1'b0;
      pass_q    <= 1'b0;
      wdog      <= '0;
    end else if (state == S_RUN) begin
      if (VIN) begin
        wdog    <= '0;
        smp_cnt <= smp_cnt + S_ONE;
        if (mism) begin
          if (err_cnt != '1)  err_cnt <= err_cnt + E_ONE;
          if (err_cnt == '0)  first_idx <= smp_cnt[AW-1:0];
        end
        if (last) pass_q <= !mism && (err_cnt == '0);
      end else if (wd_exp) begin
        tmo_q  <= 1'b1;
        pass_q <= 1'b0;
      end else begin
        wdog <= wdog + WD_ONE;
      end
    end
  end

endmodule
